// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle RISC processor front end:
//   - instruction-class codes driven on func (FUNC_R/I/J/S)
//   - opcode ranges that map imem_rdata[15:12] onto those classes
//   - pc_sel encodings (PCSEL_INC/JREL/ABS/HOLD)
//   - fetch-unit FSM state type and state constants
//   - opcode_class(): opcode -> instruction class
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Instruction class codes seen by the decoder
    localparam logic [1:0] FUNC_R = 2'b00;
    localparam logic [1:0] FUNC_I = 2'b01;
    localparam logic [1:0] FUNC_J = 2'b10;
    localparam logic [1:0] FUNC_S = 2'b11;

    // Last opcode of each class; opcodes above OPC_J_LAST are S-class
    localparam logic [3:0] OPC_R_LAST = 4'd3;
    localparam logic [3:0] OPC_I_LAST = 4'd9;
    localparam logic [3:0] OPC_J_LAST = 4'd12;

    // PC source select for pc_load
    localparam logic [1:0] PCSEL_INC  = 2'b00;
    localparam logic [1:0] PCSEL_JREL = 2'b01;
    localparam logic [1:0] PCSEL_ABS  = 2'b10;
    localparam logic [1:0] PCSEL_HOLD = 2'b11;

    // Fetch FSM state
    typedef logic [1:0] ifu_state_t;
    localparam ifu_state_t ST_IDLE  = 2'd0;
    localparam ifu_state_t ST_WAIT  = 2'd1;
    localparam ifu_state_t ST_KILL  = 2'd2;
    localparam ifu_state_t ST_FAULT = 2'd3;

    function automatic logic [1:0] opcode_class(input logic [3:0] opc);
        logic [1:0] cls;
        if (opc <= OPC_R_LAST)
            cls = FUNC_R;
        else if (opc <= OPC_I_LAST)
            cls = FUNC_I;
        else if (opc <= OPC_J_LAST)
            cls = FUNC_J;
        else
            cls = FUNC_S;
        return cls;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Request/valid bus between the fetch unit and instruction memory.
//   imem_req    fetch unit -> memory   request, held until imem_valid is seen
//   imem_addr   fetch unit -> memory   word address (ADDR_W bits)
//   imem_rdata  memory -> fetch unit   16-bit instruction word
//   imem_valid  memory -> fetch unit   response strobe
// Modports: master (fetch unit side), slave (memory side).
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/pc_next_calc.sv
// -----------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC selection.
//   pc_base    in  ADDR_W  PC the update is relative to
//   pc_sel     in  2       INC: base+1, JREL: base+sext(offset), ABS: pc_target,
//                          HOLD: base
//   offset     in  12      two's-complement jump offset (instr[11:0])
//   pc_target  in  ADDR_W  absolute target
//   pc_next    out ADDR_W  selected PC, modulo 2^ADDR_W
// -----------------------------------------------------------------------------
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc_base,
    input  logic [1:0]        pc_sel,
    input  logic [11:0]       offset,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc_next
);

    logic signed [11:0]       off_s;
    logic signed [ADDR_W-1:0] off_ext;

    assign off_s   = offset;
    // Signed source, so the size cast sign-extends
    assign off_ext = ADDR_W'(off_s);

    always_comb begin
        pc_next = pc_base;
        case (pc_sel)
            PCSEL_INC:  pc_next = pc_base + ADDR_W'(1);
            PCSEL_JREL: pc_next = pc_base + $unsigned(off_ext);
            PCSEL_ABS:  pc_next = pc_target;
            default:    pc_next = pc_base;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, runs the request/valid handshake with instruction
// memory and latches the fetched word into the instruction register.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   fetch_en       pulse: start a fetch at pc (ignored outside IDLE)
//   pc_load        pulse: update pc according to pc_sel
//   pc_sel         INC / JREL / ABS / HOLD
//   pc_target      absolute target for PCSEL_ABS
//   imem           instr_fetch_unit_if.master (req/addr out, rdata/valid in)
//   instr, func    instruction register and its class code
//   pc             current PC
//   ir_valid       instr/func hold a fetched, non-discarded word
//   busy           a memory access is outstanding (WAIT or KILL)
//   fetch_fault    sticky memory-timeout flag
//
// Optional feature: define IFU_TIMEOUT_EN to add a wait counter that moves the
// FSM to FAULT after TIMEOUT_CYCLES consecutive request cycles without
// imem_valid. Without it fetch_fault is constant 0 and the FSM waits forever.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_en,
    input  logic                      pc_load,
    input  logic [1:0]                pc_sel,
    input  logic [ADDR_W-1:0]         pc_target,
    instr_fetch_unit_if.master        imem,
    output logic [15:0]               instr,
    output logic [1:0]                func,
    output logic [ADDR_W-1:0]         pc,
    output logic                      ir_valid,
    output logic                      busy,
    output logic                      fetch_fault
);

    ifu_state_t        state;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_base;
    logic [ADDR_W-1:0] pc_next;
    logic              fetch_pend;
    logic              fetch_go;
    logic              timeout;

    // A second redirect while a kill is pending builds on the already recorded
    // target rather than on the PC of the access being drained.
    assign pc_base = (state == ST_KILL) ? redir_pc : pc;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_base   (pc_base),
        .pc_sel    (pc_sel),
        .offset    (instr[11:0]),
        .pc_target (pc_target),
        .pc_next   (pc_next)
    );

    // fetch_pend carries a fetch_en that arrived together with pc_load, so the
    // request goes out one cycle later with the updated PC.
    assign fetch_go = fetch_en | fetch_pend;

    assign busy           = (state == ST_WAIT) || (state == ST_KILL);
    assign imem.imem_req  = busy;
    // pc is frozen while an access is outstanding, so the address is stable
    assign imem.imem_addr = pc;

`ifdef IFU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (busy && !imem.imem_valid)
            wait_cnt <= wait_cnt + TO_W'(1);
        else
            wait_cnt <= '0;
    end

    // Fires on the last of TIMEOUT_CYCLES consecutive empty request cycles
    assign timeout     = busy && !imem.imem_valid &&
                         (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign fetch_fault = (state == ST_FAULT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign fetch_fault        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            redir_pc   <= RESET_PC;
            instr      <= '0;
            func       <= FUNC_R;
            ir_valid   <= 1'b0;
            fetch_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_load)
                        pc <= pc_next;
                    if (fetch_go) begin
                        ir_valid <= 1'b0;
                        if (pc_load) begin
                            fetch_pend <= 1'b1;
                        end else begin
                            fetch_pend <= 1'b0;
                            state      <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (imem.imem_valid) begin
                        state <= ST_IDLE;
                        if (pc_load) begin
                            // Redirect coincides with the response: drop the word
                            pc <= pc_next;
                        end else begin
                            instr    <= imem.imem_rdata;
                            func     <= opcode_class(imem.imem_rdata[15:12]);
                            pc       <= pc + ADDR_W'(1);
                            ir_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= ST_FAULT;
                    end else if (pc_load) begin
                        redir_pc <= pc_next;
                        state    <= ST_KILL;
                    end
                end

                ST_KILL: begin
                    if (imem.imem_valid) begin
                        state <= ST_IDLE;
                        pc    <= pc_load ? pc_next : redir_pc;
                    end else if (timeout) begin
                        state <= ST_FAULT;
                    end else if (pc_load) begin
                        redir_pc <= pc_next;
                    end
                end

                default: begin
                    // FAULT: only reset leaves this state
                    state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Randomised scoreboard bench for instr_fetch_unit. Stimulus pushes the
// expected outcome of every memory access into exp_q; a monitor pops and
// compares when the request ends. A reference model tracks pc / IR / class.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        pc_load = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [15:0] pc_target = 16'h0000;
    logic [15:0] instr;
    logic [1:0]  func;
    logic [15:0] pc;
    logic        ir_valid;
    logic        busy;
    logic        fetch_fault;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) ifc ();

    instr_fetch_unit #(
        .ADDR_W         (ADDR_W),
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .pc_load     (pc_load),
        .pc_sel      (pc_sel),
        .pc_target   (pc_target),
        .imem        (ifc),
        .instr       (instr),
        .func        (func),
        .pc          (pc),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [15:0] addr;
        int          busy_n;
        int          lat;
        logic        irv;
        logic [15:0] ins;
        logic [1:0]  fn;
        logic [15:0] pcv;
        logic        flt;
        int          cyc0;
    } exp_t;

    exp_t exp_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mdl_pc = RESET_PC;
    logic [15:0] mdl_ir = 16'h0000;
    logic [1:0]  mdl_fn = 2'b00;

    function automatic logic [1:0] mdl_class(input logic [3:0] op);
        if (op <= 4'd3)       return 2'b00;
        else if (op <= 4'd9)  return 2'b01;
        else if (op <= 4'd12) return 2'b10;
        else                  return 2'b11;
    endfunction

    function automatic logic [15:0] mdl_next(input logic [15:0] p, input logic [1:0] s,
                                             input logic [15:0] t, input logic [15:0] ir);
        int off;
        int r;
        off = int'(ir[11:0]);
        if (off >= 2048) off = off - 4096;
        case (s)
            2'b00:   r = int'(p) + 1;
            2'b01:   r = int'(p) + off;
            2'b10:   r = int'(t);
            default: r = int'(p);
        endcase
        r = ((r % 65536) + 65536) % 65536;
        return 16'(r);
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] a, input int bn, input int lt,
                                    input logic iv, input logic [15:0] ins, input logic [1:0] fn,
                                    input logic [15:0] pv, input logic fl, input int c0);
        exp_t e;
        e.addr = a; e.busy_n = bn; e.lat = lt; e.irv = iv; e.ins = ins;
        e.fn = fn; e.pcv = pv; e.flt = fl; e.cyc0 = c0;
        return e;
    endfunction

    // ---------------- memory responder ----------------
    int          rsp_delay = 0;
    logic        rsp_hold  = 1'b0;
    logic        spur      = 1'b0;
    logic [15:0] rsp_word  = 16'h0000;

    initial begin : responder
        int cnt;
        cnt = 0;
        ifc.imem_valid = 1'b0;
        ifc.imem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (spur) begin
                ifc.imem_valid = 1'b1;
                ifc.imem_rdata = rsp_word;
                cnt = 0;
            end else if (ifc.imem_req === 1'b1 && !rsp_hold) begin
                if (cnt >= rsp_delay) begin
                    ifc.imem_valid = 1'b1;
                    ifc.imem_rdata = rsp_word;
                    cnt = 0;
                end else begin
                    ifc.imem_valid = 1'b0;
                    ifc.imem_rdata = 16'($urandom);
                    cnt++;
                end
            end else begin
                ifc.imem_valid = 1'b0;
                ifc.imem_rdata = 16'($urandom);
                cnt = (ifc.imem_req === 1'b1) ? cnt + 1 : 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        prev_req;
        logic [15:0] held_addr;
        int          busy_n;
        exp_t        e;
        prev_req = 1'b0;
        held_addr = 16'h0000;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (ifc.imem_req === 1'b1) begin
                if (!prev_req) begin
                    busy_n = 0;
                    held_addr = ifc.imem_addr;
                    if (exp_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL req_unexpected: request at 0x%0h, expected none", ifc.imem_addr);
                    end else begin
                        check("req_addr", ifc.imem_addr, exp_q[0].addr);
                    end
                end else begin
                    check("addr_stable", ifc.imem_addr, held_addr);
                end
                if (busy === 1'b1) busy_n++;
                prev_req = 1'b1;
            end else begin
                if (prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL req_end_unexpected: request ended, expected no access");
                    end else begin
                        e = exp_q.pop_front();
                        check("ir_valid", ir_valid, e.irv);
                        check("instr", instr, e.ins);
                        check("func", func, e.fn);
                        check("pc", pc, e.pcv);
                        check("fetch_fault", fetch_fault, e.flt);
                        check("busy_end", busy, 1'b0);
                        if (e.busy_n >= 0) check("busy_cycles", busy_n, e.busy_n);
                        if (e.lat >= 0) check("latency", cyc_cnt - e.cyc0, e.lat);
                    end
                end
                prev_req = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy();
        int i;
        i = 0;
        while (busy === 1'b1 && i < 200) begin
            tick();
            i++;
        end
        if (i >= 200) check("access_done_bound", busy, 1'b0);
    endtask

    task automatic idle_load(input logic [1:0] sel, input logic [15:0] tgt);
        mdl_pc = mdl_next(mdl_pc, sel, tgt, mdl_ir);
        pc_load = 1'b1; pc_sel = sel; pc_target = tgt;
        tick();
        pc_load = 1'b0;
        @(negedge clk);
        check("idle_pc_load", pc, mdl_pc);
        tick();
    endtask

    task automatic fetch(input int delay, input logic [15:0] word,
                         input bit sim, input logic [1:0] lsel, input logic [15:0] ltgt,
                         input int redir_at, input logic [1:0] rsel, input logic [15:0] rtgt);
        exp_t        e;
        logic [15:0] addr;
        if (sim) mdl_pc = mdl_next(mdl_pc, lsel, ltgt, mdl_ir);
        addr = mdl_pc;
        if (redir_at >= 0) begin
            mdl_pc = mdl_next(addr, rsel, rtgt, mdl_ir);
            e = mk_exp(addr, delay + 1, delay + 2 + (sim ? 1 : 0), 1'b0, mdl_ir, mdl_fn,
                       mdl_pc, 1'b0, cyc_cnt);
        end else begin
            mdl_ir = word;
            mdl_fn = mdl_class(word[15:12]);
            mdl_pc = mdl_next(addr, 2'b00, 16'h0000, mdl_ir);
            e = mk_exp(addr, delay + 1, delay + 2 + (sim ? 1 : 0), 1'b1, mdl_ir, mdl_fn,
                       mdl_pc, 1'b0, cyc_cnt);
        end
        exp_q.push_back(e);
        rsp_delay = delay;
        rsp_word  = word;
        fetch_en = 1'b1;
        if (sim) begin
            pc_load = 1'b1; pc_sel = lsel; pc_target = ltgt;
        end
        tick();
        fetch_en = 1'b0;
        pc_load  = 1'b0;
        if (sim) tick();
        if (redir_at >= 0) begin
            repeat (redir_at) tick();
            pc_load = 1'b1; pc_sel = rsel; pc_target = rtgt;
            tick();
            pc_load = 1'b0;
        end
        wait_not_busy();
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int   d;
        int   mode;
        int   j;

        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 16'h0000);
        check("rst_func", func, 2'b00);
        check("rst_ir_valid", ir_valid, 1'b0);
        check("rst_req", ifc.imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // zero-wait fetch
        fetch(0, 16'h4A25, 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
        // three wait cycles
        fetch(3, 16'($urandom), 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
        // jump-relative -2 from pc=5
        idle_load(2'b10, 16'h0004);
        fetch(1, 16'hAFFE, 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
        idle_load(2'b01, 16'h0000);
        // pc wrap on fetch, then -1 from 0
        idle_load(2'b10, 16'hFFFF);
        fetch(0, 16'hAFFF, 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
        idle_load(2'b01, 16'h0000);
        idle_load(2'b11, 16'h1234);
        idle_load(2'b00, 16'h1234);
        // redirect during WAIT, then the next fetch uses the new pc
        fetch(3, 16'h1357, 0, 2'b00, 16'h0000, 1, 2'b10, 16'h0100);
        fetch(0, 16'h2468, 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
        // redirect in the same cycle as imem_valid
        fetch(2, 16'hD00D, 0, 2'b00, 16'h0000, 2, 2'b10, 16'h0200);
        // simultaneous pc_load + fetch_en in IDLE
        fetch(1, 16'h7777, 1, 2'b10, 16'h0040, -1, 2'b00, 16'h0000);

        // reset in the middle of WAIT, then a stray imem_valid
        rsp_hold = 1'b1;
        rsp_word = 16'($urandom);
        e = mk_exp(mdl_pc, -1, -1, 1'b0, 16'h0000, 2'b00, RESET_PC, 1'b0, cyc_cnt);
        exp_q.push_back(e);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mdl_pc = RESET_PC; mdl_ir = 16'h0000; mdl_fn = 2'b00;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        @(negedge clk);
        check("late_valid_ir_valid", ir_valid, 1'b0);
        check("late_valid_instr", instr, 16'h0000);
        check("late_valid_pc", pc, RESET_PC);
        check("late_valid_req", ifc.imem_req, 1'b0);
        rsp_hold = 1'b0;
        tick();

        // randomised traffic
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 4);
            mode = $urandom_range(0, 3);
            case (mode)
                0: fetch(d, 16'($urandom), 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
                1: begin
                    idle_load(2'($urandom_range(0, 3)), 16'($urandom));
                    fetch(d, 16'($urandom), 0, 2'b00, 16'h0000, -1, 2'b00, 16'h0000);
                end
                2: begin
                    j = $urandom_range(0, d);
                    fetch(d, 16'($urandom), 0, 2'b00, 16'h0000, j,
                          2'($urandom_range(0, 3)), 16'($urandom));
                end
                default: fetch(d, 16'($urandom), 1, 2'($urandom_range(0, 3)), 16'($urandom),
                               -1, 2'b00, 16'h0000);
            endcase
        end

`ifdef IFU_TIMEOUT_EN
        // memory never answers: FAULT after 15 empty request cycles
        rsp_hold = 1'b1;
        e = mk_exp(mdl_pc, 15, -1, 1'b0, mdl_ir, mdl_fn, mdl_pc, 1'b1, cyc_cnt);
        exp_q.push_back(e);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("fault_set", fetch_fault, 1'b1);
        check("fault_req", ifc.imem_req, 1'b0);
        tick();
        fetch_en = 1'b1; pc_load = 1'b1; pc_sel = 2'b10; pc_target = 16'h1234;
        tick();
        fetch_en = 1'b0; pc_load = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("fault_sticky", fetch_fault, 1'b1);
        check("fault_req_low", ifc.imem_req, 1'b0);
        check("fault_pc_frozen", pc, mdl_pc);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("fault_cleared", fetch_fault, 1'b0);
        check("fault_rst_pc", pc, RESET_PC);
        mdl_pc = RESET_PC; mdl_ir = 16'h0000; mdl_fn = 2'b00;
        rsp_hold = 1'b0;
        tick();
`endif

        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 50) begin
                tick();
                k++;
            end
            check("sb_drain", exp_q.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
